// File: rtl/debug_host_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : debug_host_ctrl_if
// Brief    : Command/response byte streams plus the subsystem debug bus.
// Revision : 1.0
// ============================================================================
interface debug_host_ctrl_if #(
  parameter int DATA_W         = 8,
  parameter int INST_W         = 16,
  parameter int D_ADDR_W       = 12,
  parameter int I_ADDR_W       = 12,
  parameter int REG_ADDR_WIDTH = 4
) ();
  logic                      cmd_valid;
  logic [DATA_W-1:0]         cmd_data;
  logic                      cmd_ready;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_ready;
  logic                      busy;
  logic                      debug_enable;
  logic [REG_ADDR_WIDTH-1:0] reg_debug_addr;
  logic [D_ADDR_W-1:0]       dmem_debug_addr;
  logic [I_ADDR_W-1:0]       imem_debug_addr;
  logic [DATA_W-1:0]         reg_debug_rdata;
  logic [DATA_W-1:0]         dmem_debug_rdata;
  logic [INST_W-1:0]         imem_debug_rdata;

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    input  reg_debug_rdata, dmem_debug_rdata, imem_debug_rdata,
    output cmd_ready, rsp_valid, rsp_data, busy, debug_enable,
    output reg_debug_addr, dmem_debug_addr, imem_debug_addr
  );

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    output reg_debug_rdata, dmem_debug_rdata, imem_debug_rdata,
    input  cmd_ready, rsp_valid, rsp_data, busy, debug_enable,
    input  reg_debug_addr, dmem_debug_addr, imem_debug_addr
  );
endinterface
`default_nettype wire

// File: rtl/debug_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debug_host_ctrl
// Brief    : Byte-stream debug initiator for the turtle_cpu_subsystem debug port.
// Revision : 1.0
// ============================================================================
module debug_host_ctrl #(
  parameter int DATA_W         = 8,
  parameter int INST_W         = 16,
  parameter int D_ADDR_W       = 12,
  parameter int I_ADDR_W       = 12,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int READ_LATENCY   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  debug_host_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_WAIT    = 3'd3,
    S_RSP_HI  = 3'd4,
    S_RSP_LO  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    K_REG  = 2'd0,
    K_DMEM = 2'd1,
    K_IMEM = 2'd2,
    K_CTRL = 2'd3
  } kind_t;

  localparam logic [2:0]        c_LAT      = 3'(READ_LATENCY);
  localparam logic [DATA_W-1:0] c_CTRL_ACK = 8'hA5;

  state_t                    r_state,     w_state_nxt;
  kind_t                     r_kind,      w_kind_nxt;
  logic [7:0]                r_addr_hi,   w_addr_hi_nxt;
  logic [2:0]                r_cnt,       w_cnt_nxt;
  logic                      r_sampled,   w_sampled_nxt;
  logic [INST_W-1:0]         r_cap,       w_cap_nxt;
  logic                      r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]         r_rsp_data,  w_rsp_data_nxt;
  logic                      r_dbg_en,    w_dbg_en_nxt;
  logic [REG_ADDR_WIDTH-1:0] r_reg_addr,  w_reg_addr_nxt;
  logic [D_ADDR_W-1:0]       r_dmem_addr, w_dmem_addr_nxt;
  logic [I_ADDR_W-1:0]       r_imem_addr, w_imem_addr_nxt;

  logic w_cmd_ready;
  logic w_cmd_fire;
  logic w_rsp_fire;

  assign w_cmd_ready = (r_state == S_IDLE) || (r_state == S_ADDR_HI) || (r_state == S_ADDR_LO);
  assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
  assign w_rsp_fire  = r_rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_kind      <= K_REG;
      r_addr_hi   <= '0;
      r_cnt       <= '0;
      r_sampled   <= 1'b0;
      r_cap       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_dbg_en    <= 1'b0;
      r_reg_addr  <= '0;
      r_dmem_addr <= '0;
      r_imem_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_kind      <= w_kind_nxt;
      r_addr_hi   <= w_addr_hi_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sampled   <= w_sampled_nxt;
      r_cap       <= w_cap_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_dbg_en    <= w_dbg_en_nxt;
      r_reg_addr  <= w_reg_addr_nxt;
      r_dmem_addr <= w_dmem_addr_nxt;
      r_imem_addr <= w_imem_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_kind_nxt      = r_kind;
    w_addr_hi_nxt   = r_addr_hi;
    w_cnt_nxt       = r_cnt;
    w_sampled_nxt   = r_sampled;
    w_cap_nxt       = r_cap;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_dbg_en_nxt    = r_dbg_en;
    w_reg_addr_nxt  = r_reg_addr;
    w_dmem_addr_nxt = r_dmem_addr;
    w_imem_addr_nxt = r_imem_addr;

    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          w_kind_nxt = kind_t'(bus.cmd_data[7:6]);
          case (kind_t'(bus.cmd_data[7:6]))
            K_REG:          w_state_nxt = S_ADDR_LO;
            K_DMEM, K_IMEM: w_state_nxt = S_ADDR_HI;
            default: begin
              w_dbg_en_nxt    = bus.cmd_data[0];
              w_rsp_data_nxt  = c_CTRL_ACK;
              w_rsp_valid_nxt = 1'b1;
              w_state_nxt     = S_RSP_LO;
            end
          endcase
        end
      end

      S_ADDR_HI: begin
        if (w_cmd_fire) begin
          w_addr_hi_nxt = bus.cmd_data;
          w_state_nxt   = S_ADDR_LO;
        end
      end

      S_ADDR_LO: begin
        if (w_cmd_fire) begin
          // Truncating casts drop the excess high-byte bits for narrow memories.
          case (r_kind)
            K_REG:   w_reg_addr_nxt  = bus.cmd_data[REG_ADDR_WIDTH-1:0];
            K_DMEM:  w_dmem_addr_nxt = D_ADDR_W'({r_addr_hi, bus.cmd_data});
            K_IMEM:  w_imem_addr_nxt = I_ADDR_W'({r_addr_hi, bus.cmd_data});
            default: ;
          endcase
          w_cnt_nxt     = c_LAT;
          w_sampled_nxt = 1'b0;
          w_state_nxt   = S_WAIT;
        end
      end

      S_WAIT: begin
        // rdata is registered when the count hits zero; the response byte is
        // launched from that capture on the following cycle.
        if (!r_sampled) begin
          if (r_cnt == 3'd0) begin
            w_sampled_nxt = 1'b1;
            case (r_kind)
              K_IMEM:  w_cap_nxt = bus.imem_debug_rdata;
              K_DMEM:  w_cap_nxt = INST_W'(bus.dmem_debug_rdata);
              default: w_cap_nxt = INST_W'(bus.reg_debug_rdata);
            endcase
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end else begin
          w_rsp_valid_nxt = 1'b1;
          if (r_kind == K_IMEM) begin
            w_rsp_data_nxt = r_cap[15:8];
            w_state_nxt    = S_RSP_HI;
          end else begin
            w_rsp_data_nxt = r_cap[7:0];
            w_state_nxt    = S_RSP_LO;
          end
        end
      end

      S_RSP_HI: begin
        if (w_rsp_fire) begin
          w_rsp_data_nxt = r_cap[7:0];
          w_state_nxt    = S_RSP_LO;
        end
      end

      S_RSP_LO: begin
        if (w_rsp_fire) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.cmd_ready       = w_cmd_ready;
  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_data        = r_rsp_data;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.debug_enable    = r_dbg_en;
  assign bus.reg_debug_addr  = r_reg_addr;
  assign bus.dmem_debug_addr = r_dmem_addr;
  assign bus.imem_debug_addr = r_imem_addr;

endmodule
`default_nettype wire

// File: tb/tb_debug_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_host_ctrl
// Brief    : Directed self-checking bench with a transaction-level response model.
// Revision : 1.0
// ============================================================================
module tb_debug_host_ctrl;
  localparam int DATA_W   = 8;
  localparam int INST_W   = 16;
  localparam int D_ADDR_W = 12;
  localparam int I_ADDR_W = 12;
  localparam int REG_W    = 4;
  localparam int LAT      = 3;

  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  debug_host_ctrl_if #(
    .DATA_W(DATA_W), .INST_W(INST_W), .D_ADDR_W(D_ADDR_W),
    .I_ADDR_W(I_ADDR_W), .REG_ADDR_WIDTH(REG_W)
  ) bus ();

  debug_host_ctrl #(
    .DATA_W(DATA_W), .INST_W(INST_W), .D_ADDR_W(D_ADDR_W),
    .I_ADDR_W(I_ADDR_W), .REG_ADDR_WIDTH(REG_W), .READ_LATENCY(LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory contents seen through the debug port
  function automatic logic [7:0] reg_val(input int a);
    return (a == 3) ? 8'h5A : 8'(32'hC0 | a);
  endfunction
  function automatic logic [7:0] dmem_val(input int a);
    return (a == 'h72C) ? 8'h9E : (8'(a) ^ 8'h33);
  endfunction
  function automatic logic [15:0] imem_val(input int a);
    return (a == 'hFFF) ? 16'hBEEF : 16'(a * 3 + 'h1234);
  endfunction

  assign bus.reg_debug_rdata  = reg_val(int'(bus.reg_debug_addr));
  assign bus.dmem_debug_rdata = dmem_val(int'(bus.dmem_debug_addr));
  assign bus.imem_debug_rdata = imem_val(int'(bus.imem_debug_addr));

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         m_reg, m_dmem, m_imem;
  logic       m_en;
  logic [7:0] last_rsp;
  logic       prev_stall;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_reg  = 0;
    m_dmem = 0;
    m_imem = 0;
    m_en   = 1'b0;
  endtask

  task automatic model_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [15:0] w;
    case (b0[7:6])
      2'b00: begin
        m_reg = int'(b1[REG_W-1:0]);
        exp_q.push_back(reg_val(m_reg));
      end
      2'b01: begin
        m_dmem = int'({b1, b2}) % (1 << D_ADDR_W);
        exp_q.push_back(dmem_val(m_dmem));
      end
      2'b10: begin
        m_imem = int'({b1, b2}) % (1 << I_ADDR_W);
        w = imem_val(m_imem);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
      default: begin
        m_en = b0[0];
        exp_q.push_back(8'hA5);
      end
    endcase
  endtask

  // Returns just after the accepting clock edge.
  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: actual cmd_ready 0x%0h, required 0x1", bus.cmd_ready);
    end
    @(posedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    if (b0[7:6] == 2'b00) begin
      send_byte(b1);
    end else if (b0[7:6] != 2'b11) begin
      send_byte(b1);
      send_byte(b2);
    end
    model_cmd(b0, b1, b2);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #4;
      if (bus.busy === 1'b0 && exp_q.size() == 0) break;
      k++;
      if (k > 200) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: actual busy 0x%0h pending %0d, required busy 0x0 pending 0",
                 bus.busy, exp_q.size());
        break;
      end
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-low-phase.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_debug_enable", bus.debug_enable, 0);
        check("rst_reg_addr", bus.reg_debug_addr, 0);
        check("rst_dmem_addr", bus.dmem_debug_addr, 0);
        check("rst_imem_addr", bus.imem_debug_addr, 0);
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("rsp_hold_valid", bus.rsp_valid, 1);
          check("rsp_hold_data", bus.rsp_data, prev_data);
        end
        if (bus.rsp_valid === 1'b1) check("cmd_ready_during_rsp", bus.cmd_ready, 0);
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: actual byte 0x%0h, required no response", bus.rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", bus.rsp_data, e);
            last_rsp = bus.rsp_data;
          end
        end
        if (bus.busy === 1'b0) begin
          check("idle_cmd_ready", bus.cmd_ready, 1);
          check("idle_rsp_valid", bus.rsp_valid, 0);
          check("idle_debug_enable", bus.debug_enable, m_en);
          check("idle_reg_addr", bus.reg_debug_addr, m_reg);
          check("idle_dmem_addr", bus.dmem_debug_addr, m_dmem);
          check("idle_imem_addr", bus.imem_debug_addr, m_imem);
        end
        prev_stall = bus.rsp_valid && !bus.rsp_ready;
        prev_data  = bus.rsp_data;
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'hC1;
    bus.rsp_ready = 1'b1;
    prev_stall    = 1'b0;
    last_rsp      = 8'h00;
    model_reset();

    // CTRL 0xC1 held through reset is taken on the first edge after release
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    model_cmd(8'hC1, 8'h00, 8'h00);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #4;
    check("ctrl_c1_enable", bus.debug_enable, 1);
    wait_done();
    check("ctrl_c1_rsp", last_rsp, 8'hA5);

    send_cmd(8'hC0, 8'h00, 8'h00);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #4;
    check("ctrl_c0_enable", bus.debug_enable, 0);
    wait_done();
    check("ctrl_c0_rsp", last_rsp, 8'hA5);

    // REG read of address 3
    send_cmd(8'h00, 8'h03, 8'h00);
    wait_done();
    check("reg_addr", bus.reg_debug_addr, 4'd3);
    check("reg_rsp", last_rsp, 8'h5A);
    check("reg_dmem_untouched", bus.dmem_debug_addr, 12'h000);
    check("reg_imem_untouched", bus.imem_debug_addr, 12'h000);

    // DMEM read, excess high nibble dropped; latency measured from last accept
    send_cmd(8'h40, 8'hF7, 8'h2C);
    k = 0;
    forever begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #4;
      if (bus.rsp_valid === 1'b1 || k > 40) break;
      k++;
    end
    check("dmem_latency", k, LAT + 2);
    wait_done();
    check("dmem_addr", bus.dmem_debug_addr, 12'h72C);
    check("dmem_rsp", last_rsp, 8'h9E);
    check("dmem_reg_hold", bus.reg_debug_addr, 4'd3);

    // IMEM read under response backpressure
    bus.rsp_ready = 1'b0;
    send_cmd(8'h80, 8'h0F, 8'hFF);
    k = 0;
    forever begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #4;
      if (bus.rsp_valid === 1'b1 || k > 40) break;
      k++;
    end
    check("imem_rsp_wait", bus.rsp_valid, 1);
    repeat (10) begin
      @(negedge clk);
      #4;
      check("imem_hi_hold", bus.rsp_data, 8'hBE);
      check("imem_cmd_ready_low", bus.cmd_ready, 0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #4;
    check("imem_lo_valid", bus.rsp_valid, 1);
    check("imem_lo_data", bus.rsp_data, 8'hEF);
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    wait_done();
    check("imem_addr", bus.imem_debug_addr, 12'hFFF);
    check("imem_last_rsp", last_rsp, 8'hEF);
    check("imem_idle", bus.busy, 0);

    // Reset while waiting on a DMEM read abandons it
    send_cmd(8'h40, 8'h01, 8'h23);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    #4;
    check("abort_busy", bus.busy, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_dmem_addr", bus.dmem_debug_addr, 12'h000);

    send_cmd(8'h00, 8'h07, 8'h00);
    wait_done();
    check("post_abort_reg_addr", bus.reg_debug_addr, 4'd7);
    check("post_abort_rsp", last_rsp, 8'hC7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
